// File: rtl/ascon_stream_pkg.sv
// Shared types and sizing for the Ascon-128a stream wrapper and its serializer.
// Imported by the top and the output serializer.
package ascon_stream_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    SEND
  } state_t;

  localparam int IN_WORDS         = 16;
  localparam int OUT_WORDS        = 8;
  localparam int WORD_W           = 32;
  localparam int CORE_LAT_DEFAULT = 27;

endpackage

// File: rtl/ascon_word_serializer.sv
// Holds a 256-bit result and presents it MSW first as a 32-bit valid/ready stream.
// The word counter wraps to 0 after the last word, ready for the next load.
module ascon_word_serializer
  import ascon_stream_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [OUT_WORDS*WORD_W-1:0] load_data,
  input  logic                        valid,
  input  logic                        ready,
  output logic [WORD_W-1:0]           data,
  output logic                        last,
  output logic                        done
);

  logic [OUT_WORDS*WORD_W-1:0] buffer;
  logic [2:0]                  out_cnt;
  logic [7:0]                  rd_base;

  // Word 0 lives in the top bits, so the slice base is (7 - out_cnt) * 32.
  assign rd_base = {~out_cnt, 5'd0};
  assign data    = buffer[rd_base +: WORD_W];
  assign last    = valid && (out_cnt == 3'(OUT_WORDS - 1));
  assign done    = valid && ready && last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buffer  <= '0;
      out_cnt <= '0;
    end else begin
      if (load) begin
        buffer <= load_data;
      end
      if (valid && ready) begin
        out_cnt <= out_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ascon_stream_wrapper_128a.sv
// Stream front/back end for the Ascon-128a core: loads 16 words, runs the core
// for a fixed number of edges, then streams out ciphertext and tag.
module ascon_stream_wrapper_128a
  import ascon_stream_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          busy,
  output logic          core_reset,
  output logic [127:0]  core_sk,
  output logic [127:0]  core_n,
  output logic [127:0]  core_a,
  output logic [127:0]  core_p,
  input  logic [127:0]  core_c,
  input  logic [127:0]  core_t
);

  state_t                     state;
  state_t                     state_next;
  logic [3:0]                 in_cnt;
  logic [4:0]                 run_cnt;
  logic [IN_WORDS*WORD_W-1:0] operands;
  logic [8:0]                 wr_base;
  logic                       load_fire;
  logic                       run_done;
  logic                       send_active;
  logic                       send_done;

  // Fire conditions come straight from the state so they never loop through the decode.
  assign load_fire   = (state == LOAD) && s_valid;
  assign run_done    = (state == RUN) && (run_cnt == 5'(CORE_LAT));
  assign send_active = (state == SEND);
  assign wr_base     = {~in_cnt, 5'd0};

  assign core_sk = operands[511:384];
  assign core_n  = operands[383:256];
  assign core_a  = operands[255:128];
  assign core_p  = operands[127:0];

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (load_fire && (in_cnt == 4'(IN_WORDS - 1))) begin
          state_next = RUN;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
        if (run_done) begin
          state_next = SEND;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (send_done) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Operands only move on LOAD handshakes, so they stay fixed for the whole core pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LOAD;
      in_cnt   <= '0;
      run_cnt  <= '0;
      operands <= '0;
    end else begin
      state <= state_next;
      if (load_fire) begin
        operands[wr_base +: WORD_W] <= s_data;
        in_cnt                      <= in_cnt + 4'd1;
      end
      run_cnt <= ((state == RUN) && !run_done) ? run_cnt + 5'd1 : 5'd0;
    end
  end

  ascon_word_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (run_done),
    .load_data ({core_c, core_t}),
    .valid     (send_active),
    .ready     (m_ready),
    .data      (m_data),
    .last      (m_last),
    .done      (send_done)
  );

endmodule

// File: tb/tb_ascon_stream_wrapper_128a.sv
// Self-checking bench for ascon_stream_wrapper_128a driving a fixed-latency core stub.
// Expected output is derived from the words sent, not from the wrapper's operand ports.
module tb_ascon_stream_wrapper_128a;

  localparam int LAT = 27;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         core_reset;
  logic [127:0] core_sk, core_n, core_a, core_p;
  logic [127:0] core_c, core_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] msg [16];
  logic [31:0] exp_out [8];
  bit          stub_const = 1'b0;
  bit          hammer = 1'b0;
  int          accepted = 0;
  int          core_edges = 0;

  always #5 clk = ~clk;

  ascon_stream_wrapper_128a #(.CORE_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .core_reset (core_reset),
    .core_sk    (core_sk),
    .core_n     (core_n),
    .core_a     (core_a),
    .core_p     (core_p),
    .core_c     (core_c),
    .core_t     (core_t)
  );

  // Stand-in core behaviour: an arbitrary but operand-sensitive mixing function.
  function automatic logic [127:0] stubC(input logic [127:0] sk, input logic [127:0] n,
                                         input logic [127:0] p);
    return p ^ sk ^ {n[63:0], n[127:64]};
  endfunction

  function automatic logic [127:0] stubT(input logic [127:0] sk, input logic [127:0] n,
                                         input logic [127:0] a, input logic [127:0] p);
    return a ^ {sk[95:0], sk[127:96]} ^ n ^ p;
  endfunction

  // The stub's results are only valid once it has seen LAT edges out of reset.
  always @(posedge clk) begin
    if (core_reset) core_edges <= 0;
    else if (core_edges < 100) core_edges <= core_edges + 1;
  end

  always_comb begin
    if (stub_const) begin
      core_c = {4{32'h11111111}};
      core_t = {4{32'h22222222}};
    end else begin
      core_c = stubC(core_sk, core_n, core_p);
      core_t = stubT(core_sk, core_n, core_a, core_p);
    end
    if (core_edges < LAT) begin
      core_c = ~core_c;
      core_t = ~core_t;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic randomizeMsg();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  task automatic buildExpected();
    logic [127:0] sk, n, a, p, c, t;
    sk = {msg[0], msg[1], msg[2], msg[3]};
    n  = {msg[4], msg[5], msg[6], msg[7]};
    a  = {msg[8], msg[9], msg[10], msg[11]};
    p  = {msg[12], msg[13], msg[14], msg[15]};
    if (stub_const) begin
      c = {4{32'h11111111}};
      t = {4{32'h22222222}};
    end else begin
      c = stubC(sk, n, p);
      t = stubT(sk, n, a, p);
    end
    for (int i = 0; i < 4; i++) begin
      exp_out[i]     = c[127-32*i -: 32];
      exp_out[4 + i] = t[127-32*i -: 32];
    end
  endtask

  task automatic checkOperands();
    checkOutput("core_sk", core_sk, {msg[0], msg[1], msg[2], msg[3]});
    checkOutput("core_n", core_n, {msg[4], msg[5], msg[6], msg[7]});
    checkOutput("core_a", core_a, {msg[8], msg[9], msg[10], msg[11]});
    checkOutput("core_p", core_p, {msg[12], msg[13], msg[14], msg[15]});
  endtask

  // Two reset edges with s_valid high: the second one must not record a word.
  task automatic doReset();
    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hBAD0BAD0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_ops", core_sk | core_n | core_a | core_p, 0);
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  // Sends msg[0..n-1] with random s_valid gaps; returns just after the last handshake edge.
  task automatic applyStimulus(input int n, input int gap_pct);
    int   sent = 0;
    int   cyc = 0;
    logic hs;
    logic pre_cr = 1'b0;
    while (sent < n && cyc < 2000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = msg[sent];
      hs      = s_valid && s_ready;
      if (hs && sent == 15) pre_cr = core_reset;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) sent++;
    end
    s_valid = 1'b0;
    checkOutput("load_count", sent, n);
    if (n == 16) begin
      checkOutput("core_reset_before", pre_cr, 1);
      checkOutput("core_reset_fall", core_reset, 0);
      checkOutput("run_s_ready", s_ready, 0);
      checkOutput("run_busy", busy, 1);
    end
  endtask

  task automatic waitForOutput();
    int lat = 0;
    while (!m_valid && lat < 200) begin
      s_valid = hammer;
      s_data  = $urandom;
      if (s_valid && s_ready) accepted++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("m_valid_latency", lat, LAT + 1);
  endtask

  task automatic receiveWords(input int n, input int stall_pct);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    while (got < n && cyc < 2000) begin
      m_ready = ($urandom_range(99) >= stall_pct);
      s_valid = hammer;
      s_data  = $urandom;
      if (s_valid && s_ready) accepted++;
      checkOutput("ready_valid_overlap", s_ready && m_valid, 0);
      if (stalled) checkOutput("hold_data", m_data, held);
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (m_valid && m_ready) begin
        checkOutput($sformatf("m_data%0d", got), m_data, exp_out[got]);
        checkOutput($sformatf("m_last%0d", got), m_last, (got == 7));
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    checkOutput("recv_count", got, n);
  endtask

  task automatic runMessage(input int gap_pct, input int stall_pct, input bit hmr, input bit fixed);
    if (!fixed) randomizeMsg();
    buildExpected();
    applyStimulus(16, gap_pct);
    checkOperands();
    hammer   = hmr;
    accepted = 0;
    waitForOutput();
    receiveWords(8, stall_pct);
    hammer = 1'b0;
    checkOutput("accepted_while_busy", accepted, 0);
    checkOutput("back_to_load", {s_ready, m_valid, busy}, 3'b100);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    for (int i = 0; i < 16; i++) begin
      msg[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    end
    stub_const = 1'b1;
    runMessage(0, 0, 1'b0, 1'b1);
    checkOutput("kat_sk", core_sk, 128'h000102030405060708090A0B0C0D0E0F);
    checkOutput("kat_p_low", core_p[31:0], 32'h3C3D3E3F);

    stub_const = 1'b0;
    runMessage(0, 0, 1'b0, 1'b1);
    runMessage(50, 50, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) runMessage(40, 50, 1'b1, 1'b0);

    randomizeMsg();
    applyStimulus(9, 20);
    doReset();
    runMessage(0, 30, 1'b0, 1'b0);

    randomizeMsg();
    buildExpected();
    applyStimulus(16, 0);
    repeat (13) @(posedge clk);
    #1;
    checkOutput("midrun_busy", busy, 1);
    doReset();
    runMessage(20, 20, 1'b0, 1'b0);

    randomizeMsg();
    buildExpected();
    applyStimulus(16, 0);
    waitForOutput();
    receiveWords(3, 0);
    doReset();
    runMessage(0, 50, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_stream_wrapper_128a.md
# ascon_stream_wrapper_128a

Stream-side front/back end for the two-rounds-per-cycle Ascon-128a encryption core. Deserialises key, nonce, associated data and plaintext from a 32-bit valid/ready input stream and holds them stable on the core's operand ports. Runs the core for one fixed-latency pass, then serialises ciphertext and tag onto a 32-bit valid/ready output stream. Sits directly upstream and downstream of the core; the core is instantiated alongside it, not inside it.

## Interface
- `CORE_LAT`, default 27: core rising edges from reset release until `T` is registered.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: input word accepted when `s_valid && s_ready`.
- `s_data` in 32: input word.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts.
- `m_data` out 32: output word.
- `m_last` out 1: high on the 8th (final) output word.
- `busy` out 1: high in RUN or SEND.
- `core_reset` out 1: active-high reset to the core, the core's own convention.
- `core_sk`, `core_n`, `core_a`, `core_p` out 128 each: operand registers.
- `core_c`, `core_t` in 128 each: core results.

## Operation
- FSM states LOAD, RUN, SEND. The state is registered; all handshake outputs decode from it.
- **LOAD**
  - `s_ready`=1.
  - Each handshake stores `s_data` at 4-bit `in_cnt` (0..15), MSW first: words 0-3 go to SK[127:96]..SK[31:0], 4-7 to N, 8-11 to A, 12-15 to P.
  - On the handshake with `in_cnt`=15: `in_cnt`←0, go to RUN.
- **RUN**
  - `s_ready`=0. `core_reset`=0; it is 1 in every other state.
  - 5-bit `run_cnt` starts at 0 on entry and increments each cycle.
  - When `run_cnt`==`CORE_LAT`: capture `{core_c, core_t}` into a 256-bit output buffer, go to SEND.
  - The core reruns its permutation once more on that final edge. This is harmless; it is held in reset from the next cycle.
- **SEND**
  - `m_valid`=1. `m_data` = buffer word `out_cnt` (3-bit), MSW first: words 0-3 carry C[127:96]..C[31:0], words 4-7 carry T.
  - `m_last` = (`out_cnt`==7).
  - Each handshake advances `out_cnt`. The handshake on word 7 returns to LOAD with `out_cnt`←0.
  - `m_data` is held stable while `m_valid && !m_ready`.
- Operand registers change only on LOAD handshakes. They keep their values through RUN and SEND, so they are stable for the whole core pass.
- Reset (any state, including mid-LOAD, mid-RUN or mid-SEND) forces:
  - state LOAD, all counters 0, operand registers and output buffer 0.
  - A partially loaded or partially sent message is discarded.

## Timing
- After the first clock edge with `reset`=0: `s_ready`=1, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `core_reset`=1, all `core_*` operands 0.
- While `reset`=0, no input handshake is recorded.
- Last input handshake at edge E0. `core_reset` falls after E0. The core sees `CORE_LAT` edges, E1..E27. Capture occurs at E28. `m_valid` rises after E28.
- Minimum message period is 16 + 28 + 8 = 52 cycles.
- Back-pressure: any number of `m_ready`=0 cycles stalls SEND without changing the buffer. `s_valid` gaps stall LOAD without changing `in_cnt`.
- `s_ready` and `m_valid` are never high in the same cycle.
- Input words offered during RUN or SEND are not accepted.

## Structure
- Shared package `ascon_stream_pkg`:
  - state enum {LOAD, RUN, SEND}
  - `IN_WORDS`=16, `OUT_WORDS`=8, `WORD_W`=32
  - `CORE_LAT` default value
- One sub-module, `ascon_word_serializer`: 256-bit load, 32-bit MSW-first valid/ready output, `last` flag.
- The input deserialiser stays inline as an indexed register write.

## Test plan
- Feed words 0x00010203, 0x04050607, … 0x3C3D3E3F with `s_valid` always high. Required response:
  - `core_sk`=0x000102030405060708090A0B0C0D0E0F, and `core_p` ends in 0x3C3D3E3F.
  - `core_reset` falls exactly one cycle after the 16th handshake.
- Core stub returns C=0x11…11 and T=0x22…22, valid only from edge 27 after release. Required response:
  - Output is 4×0x11111111 then 4×0x22222222, with `m_last` only on word 8.
  - `m_valid` rises 28 cycles after `core_reset` falls.
- Random `s_valid` gaps and random `m_ready` stalls (50%). Required response: identical data to the unstalled run, and no duplicated or dropped words.
- Assert `reset`=0 after input word 9, then mid-RUN (`run_cnt`=13), then mid-SEND (after word 3). Each time, required response:
  - Next cycle: LOAD, `m_valid`=0, `core_reset`=1, operands 0.
  - A fresh full message then completes correctly.
- Hold `s_valid`=1 during RUN and SEND → zero accepted words. The next message's first word lands in SK[127:96].
- Use the real core with the Ascon-128a KAT vector (key/nonce 000102…0F, 16-byte AD, 16-byte PT) → C and T on the stream match the reference model.
